// File: rtl/bist_sram.sv
// bist_sram: single-clock synchronous RAM for the BIST datapath.
//   - Separate write (data_in) and registered read (data_out + rd_valid pulse).
//   - Built-in init sequencer fills every word with a latched pattern.
//   - Single-bit stuck-at fault injector on the read path only.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   write, read, address       access strobes and word address
//   data_in / data_out         write data / registered read data
//   rd_valid                   one-cycle pulse per read result
//   init_req, init_pattern     start a full-array fill; pattern latched on accept
//   busy                       fill in progress
//   fault_en/addr/bit/val      stuck-at fault applied to reads of fault_addr
//   o_dbg_state                current sequencer state (0 = IDLE, 1 = INIT)
// Handshake: strobes are sampled on the rising edge; while busy is high every
// external write/read/init_req is ignored. A read sampled at edge T presents
// its result with rd_valid high during the cycle after T only.
module bist_sram #(
  parameter int A_WIDTH = 4,
  parameter int WIDTH   = 4,
  localparam int DEPTH  = 1 << A_WIDTH,
  localparam int FB_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write,
  input  logic               read,
  input  logic [A_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  input  logic               init_req,
  input  logic [WIDTH-1:0]   init_pattern,
  output logic               busy,
  input  logic               fault_en,
  input  logic [A_WIDTH-1:0] fault_addr,
  input  logic [FB_W-1:0]    fault_bit,
  input  logic               fault_val,
  output logic               o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [A_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]   r_pat;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_rd_valid;
  logic               w_init_accept;
  logic               w_do_write;
  logic               w_do_read;
  logic [WIDTH-1:0]   w_rd_word;

  // Array is intentionally not reset: contents survive rst_n.
  logic [WIDTH-1:0]   r_mem [DEPTH];

  // Next-state and IDLE priority decode: init_req > write > read.
  always_comb begin
    w_next_state  = r_state;
    w_init_accept = 1'b0;
    w_do_write    = 1'b0;
    w_do_read     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (init_req) begin
          w_init_accept = 1'b1;
          w_next_state  = ST_INIT;
        end else if (write) begin
          w_do_write = 1'b1;
        end else if (read) begin
          w_do_read = 1'b1;
        end
      end
      ST_INIT: begin
        if (r_cnt == A_WIDTH'(DEPTH - 1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read word with the stuck-at bit forced. An out-of-range fault_bit
  // matches no loop index and therefore has no effect.
  always_comb begin
    w_rd_word = r_mem[address];
    if (fault_en && (address == fault_addr)) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (fault_bit == FB_W'(b)) w_rd_word[b] = fault_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_pat      <= '0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_rd_valid <= w_do_read;
      if (w_do_read) r_data_out <= w_rd_word;
      if (w_init_accept) begin
        r_pat <= init_pattern;
        r_cnt <= '0;
      end else if (r_state == ST_INIT) begin
        // Wraps to 0 on the edge that writes DEPTH-1.
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_cnt] <= r_pat;
    end else if (w_do_write) begin
      r_mem[address] <= data_in;
    end
  end

  assign data_out    = r_data_out;
  assign rd_valid    = r_rd_valid;
  assign busy        = (r_state == ST_INIT);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bist_sram.sv
module tb_bist_sram;
  localparam int AW    = 4;
  localparam int W     = 4;
  localparam int DEPTH = 1 << AW;
  localparam int FBW   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          write = 0, read = 0, init_req = 0;
  logic [AW-1:0] address = 0, fault_addr = 0;
  logic [W-1:0]  data_in = 0, init_pattern = 0;
  logic          fault_en = 0, fault_val = 0;
  logic [FBW-1:0] fault_bit = 0;
  logic [W-1:0]  data_out;
  logic          rd_valid, busy, dbg_state;

  bist_sram #(.A_WIDTH(AW), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read), .address(address),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
    .init_req(init_req), .init_pattern(init_pattern), .busy(busy),
    .fault_en(fault_en), .fault_addr(fault_addr), .fault_bit(fault_bit),
    .fault_val(fault_val), .o_dbg_state(dbg_state)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0] model_mem [DEPTH];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] last_exp = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word a read of address a should return under the current fault inputs.
  function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
    logic [W-1:0] v;
    v = model_mem[a];
    if (fault_en && a == fault_addr && int'(fault_bit) < W)
      v[fault_bit] = fault_val;
    return v;
  endfunction

  // Monitor: pops one expected word per rd_valid; data_out must hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_rd_valid", 1, 0);
        end else begin
          last_exp = exp_q.pop_front();
          check("read_data", data_out, last_exp);
        end
      end else begin
        check("data_out_hold", data_out, last_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    write = 1; address = a; data_in = d;
    model_mem[a] = d;
    step();
    write = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    read = 1; address = a;
    exp_q.push_back(model_read(a));
    step();
    read = 0;
  endtask

  // Fill with pat; while busy throw junk at the ports (and optionally a
  // second init_req) which must all be ignored. Checks busy lasts DEPTH cycles.
  task automatic do_init(input logic [W-1:0] pat, input bit reinit);
    int n;
    init_req = 1; init_pattern = pat;
    write = $urandom_range(0, 1); read = $urandom_range(0, 1);
    step();
    n = 0;
    while (busy && n < 100) begin
      n++;
      write    = $urandom_range(0, 1);
      read     = $urandom_range(0, 1);
      address  = AW'($urandom_range(0, DEPTH - 1));
      data_in  = W'($urandom_range(0, (1 << W) - 1));
      init_req = reinit && (n == 5 || n == 10);
      init_pattern = ~pat;
      step();
    end
    write = 0; read = 0; init_req = 0;
    check("busy_cycles", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = pat;
  endtask

  task automatic read_all();
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    check("reset_data_out", data_out, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_busy", busy, 0);
    rst_n = 1;

    // Basic write then back-to-back reads.
    do_write(3, 4'h5);
    do_write(7, 4'hA);
    do_read(3);
    do_read(7);
    step(); step();

    // Fill with 0x9, junk ignored while busy, verify every word.
    do_init(4'h9, 0);
    read_all();

    // Fault injection.
    do_write(4, 4'h0);
    do_write(5, 4'h6);
    fault_en = 1; fault_addr = 4; fault_bit = 2; fault_val = 1;
    check("fault_model_sanity_addr4", model_read(4), 4'h4);
    do_read(4);
    do_read(5);
    fault_en = 0;
    do_read(4);
    fault_en = 1; fault_addr = 5; fault_bit = 1; fault_val = 0;
    do_read(5);
    fault_en = 0;

    // Same-cycle write + read: write wins, no rd_valid.
    write = 1; read = 1; address = 2; data_in = 4'h3;
    model_mem[2] = 4'h3;
    step();
    write = 0; read = 0;
    step();
    do_read(2);
    step();

    // Reset in the 5th cycle of a 0xF fill over an all-zero array.
    do_init(4'h0, 0);
    init_req = 1; init_pattern = 4'hF;
    step();
    init_req = 0;
    repeat (4) step();
    rst_n = 0;
    last_exp = '0;
    #1;
    check("reset_mid_init_busy", busy, 0);
    check("reset_mid_init_data_out", data_out, 0);
    check("reset_mid_init_rd_valid", rd_valid, 0);
    for (int i = 0; i < 4; i++) model_mem[i] = 4'hF;
    step();
    rst_n = 1;
    read_all();
    do_init(4'h3, 0);
    read_all();

    // Re-asserted init_req mid-fill keeps the first pattern.
    do_init(4'hC, 1);
    read_all();

    // Randomized mix.
    for (int k = 0; k < 300; k++) begin
      int op;
      op = $urandom_range(0, 19);
      fault_en   = ($urandom_range(0, 3) == 0);
      fault_addr = AW'($urandom_range(0, DEPTH - 1));
      fault_bit  = FBW'($urandom_range(0, 3));
      fault_val  = 1'($urandom_range(0, 1));
      if (op == 0) begin
        do_init(W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end else if (op < 8) begin
        do_write(AW'($urandom_range(0, DEPTH - 1)), W'($urandom_range(0, 15)));
      end else if (op < 17) begin
        do_read(AW'($urandom_range(0, DEPTH - 1)));
      end else begin
        step();
      end
    end
    fault_en = 0;
    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
